// File: rtl/sub_signed_pipe.sv
// sub_signed_pipe: pipelined two's-complement subtractor (result = a - b).
// The borrow chain is cut into CHUNK-bit slices with one slice resolved per
// stage. A stall-all valid/ready handshake moves the pipeline. The final
// stage also checks for signed overflow, saturates when asked to, and keeps a
// sticky overflow flag and a saturating overflow event counter.
module sub_signed_pipe #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             ovf_sticky,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] ovf_count
);

    localparam int L   = WIDTH / CHUNK;
    localparam int MSB = WIDTH - 1;

    // Saturation bound: MIN for a negative minuend, MAX otherwise.
    function automatic logic [WIDTH-1:0] sat_value(input logic neg);
        logic [WIDTH-1:0] v;
        v = {1'b0, {(WIDTH-1){1'b1}}};
        if (neg) begin
            v = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            v = {1'b0, {(WIDTH-1){1'b1}}};
        end
        return v;
    endfunction

    // Signed overflow of a - b. The check uses the true sign of b, so a
    // subtrahend of MIN is handled correctly.
    function automatic logic sub_overflow(input logic a_msb, input logic b_msb,
                                          input logic w_msb);
        return (a_msb != b_msb) && (w_msb != a_msb);
    endfunction

    // Per-stage state. The operand slices travel with the beat, together with
    // the bits already resolved, the carry into the next slice and sat_en.
    logic             v_r   [L];
    logic [WIDTH-1:0] a_r   [L];
    logic [WIDTH-1:0] nb_r  [L];
    logic [WIDTH-1:0] sum_r [L];
    logic             c_r   [L];
    logic             sat_r [L];

    logic [WIDTH-1:0] result_r;
    logic             overflow_r;
    logic             sticky_r;
    logic [CNT_W-1:0] count_r;
    logic             ready_r;

    // Stage inputs, meaning what flows into stage k on the next advance.
    logic             src_v_s   [L];
    logic [WIDTH-1:0] src_a_s   [L];
    logic [WIDTH-1:0] src_nb_s  [L];
    logic [WIDTH-1:0] src_sum_s [L];
    logic             src_c_s   [L];
    logic             src_sat_s [L];
    logic [CHUNK:0]   slice_s   [L];
    logic [WIDTH-1:0] nx_sum_s  [L];
    logic             nx_c_s    [L];

    logic             adv_s;
    logic             take_s;
    logic             out_fire_s;
    logic             ovf_event_s;
    logic             fin_ovf_s;
    logic [WIDTH-1:0] fin_res_s;

    assign out_valid   = v_r[L-1];
    assign adv_s       = !v_r[L-1] || out_ready;
    assign in_ready    = ready_r && adv_s;
    assign take_s      = in_valid && in_ready;
    assign out_fire_s  = v_r[L-1] && out_ready;
    assign ovf_event_s = out_fire_s && overflow_r;

    assign result     = result_r;
    assign overflow   = overflow_r;
    assign ovf_sticky = sticky_r;
    assign ovf_count  = count_r;

    // Stage datapath: route each stage's input and resolve its slice.
    always_comb begin
        for (int k = 0; k < L; k++) begin
            src_v_s[k]   = 1'b0;
            src_a_s[k]   = {WIDTH{1'b0}};
            src_nb_s[k]  = {WIDTH{1'b0}};
            src_sum_s[k] = {WIDTH{1'b0}};
            src_c_s[k]   = 1'b0;
            src_sat_s[k] = 1'b0;
            slice_s[k]   = {(CHUNK+1){1'b0}};
            nx_sum_s[k]  = {WIDTH{1'b0}};
            nx_c_s[k]    = 1'b0;
        end
        fin_ovf_s = 1'b0;
        fin_res_s = {WIDTH{1'b0}};

        // Stage 0 forms A + ~B + 1, so the initial carry-in is 1.
        src_v_s[0]   = take_s;
        src_a_s[0]   = a;
        src_nb_s[0]  = ~b;
        src_sum_s[0] = {WIDTH{1'b0}};
        src_c_s[0]   = 1'b1;
        src_sat_s[0] = sat_en;
        for (int k = 1; k < L; k++) begin
            src_v_s[k]   = v_r[k-1];
            src_a_s[k]   = a_r[k-1];
            src_nb_s[k]  = nb_r[k-1];
            src_sum_s[k] = sum_r[k-1];
            src_c_s[k]   = c_r[k-1];
            src_sat_s[k] = sat_r[k-1];
        end

        for (int k = 0; k < L; k++) begin
            slice_s[k] = {1'b0, src_a_s[k][k*CHUNK +: CHUNK]}
                       + {1'b0, src_nb_s[k][k*CHUNK +: CHUNK]}
                       + {{CHUNK{1'b0}}, src_c_s[k]};
            nx_sum_s[k] = src_sum_s[k];
            nx_sum_s[k][k*CHUNK +: CHUNK] = slice_s[k][CHUNK-1:0];
            nx_c_s[k] = slice_s[k][CHUNK];
        end

        fin_ovf_s = sub_overflow(src_a_s[L-1][MSB], ~src_nb_s[L-1][MSB],
                                 nx_sum_s[L-1][MSB]);
        if (fin_ovf_s && src_sat_s[L-1]) begin
            fin_res_s = sat_value(src_a_s[L-1][MSB]);
        end else begin
            fin_res_s = nx_sum_s[L-1];
        end
    end

    // Pipeline registers. Every stage shifts together on advance and holds on a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < L; k++) begin
                v_r[k]   <= 1'b0;
                a_r[k]   <= {WIDTH{1'b0}};
                nb_r[k]  <= {WIDTH{1'b0}};
                sum_r[k] <= {WIDTH{1'b0}};
                c_r[k]   <= 1'b0;
                sat_r[k] <= 1'b0;
            end
            result_r   <= {WIDTH{1'b0}};
            overflow_r <= 1'b0;
        end else if (adv_s) begin
            for (int k = 0; k < L; k++) begin
                v_r[k] <= src_v_s[k];
                if (src_v_s[k]) begin
                    a_r[k]   <= src_a_s[k];
                    nb_r[k]  <= src_nb_s[k];
                    sum_r[k] <= nx_sum_s[k];
                    c_r[k]   <= nx_c_s[k];
                    sat_r[k] <= src_sat_s[k];
                end
            end
            if (src_v_s[L-1]) begin
                result_r   <= fin_res_s;
                overflow_r <= fin_ovf_s;
            end
        end
    end

    // Hold off input acceptance until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= 1'b1;
        end
    end

    // Overflow statistics. An overflowing transfer takes priority over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_r <= 1'b0;
            count_r  <= {CNT_W{1'b0}};
        end else if (ovf_event_s) begin
            sticky_r <= 1'b1;
            if (ovf_clr) begin
                count_r <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (count_r != {CNT_W{1'b1}}) begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else if (ovf_clr) begin
            sticky_r <= 1'b0;
            count_r  <= {CNT_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_sub_signed_pipe.sv
// tb_sub_signed_pipe: directed bench for sub_signed_pipe (WIDTH=16, CHUNK=8).
// A scoreboard predicts every result from integer arithmetic. Literal
// expectations pin the main arithmetic cases and the statistics behaviour.
module tb_sub_signed_pipe;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          sat_en = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  result;
    logic          overflow;
    logic          ovf_sticky;
    logic          ovf_clr = 1'b0;
    logic [15:0]   ovf_count;

    int n_checks = 0;
    int n_err    = 0;

    logic [W:0]    exp_q[$];
    logic [W:0]    e;
    logic          m_sticky = 1'b0;
    logic [15:0]   m_count = 16'h0000;
    logic          fire_ovf;
    logic          stall_prev = 1'b0;
    logic [W-1:0]  held_res;
    logic          held_ovf;
    logic          warm;

    sub_signed_pipe #(.WIDTH(16), .CHUNK(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sat_en(sat_en), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .overflow(overflow),
        .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: exact integer difference, then wrap or clamp.
    function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic s);
        int ai, bi, d;
        logic [31:0] dv;
        logic ovf;
        logic [W-1:0] r;
        ai = $signed(av);
        bi = $signed(bv);
        d  = ai - bi;
        dv = d;
        ovf = (d > 32767) || (d < -32768);
        r = dv[W-1:0];
        if (ovf && s) r = (d > 0) ? 16'h7FFF : 16'h8000;
        return {ovf, r};
    endfunction

    // Set one cycle after reset release. Before that point in_ready may be low.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) warm <= 1'b0;
        else        warm <= 1'b1;
    end

    // Scoreboard, handshake and statistics checks, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_sticky   = 1'b0;
            m_count    = 16'h0000;
            stall_prev = 1'b0;
        end else begin
            chk("sticky", ovf_sticky, m_sticky);
            chk("count", ovf_count, m_count);
            if (warm) chk("in_ready", in_ready, !out_valid || out_ready);
            fire_ovf = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_output: got %h expected no beat", result);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", result, e[W-1:0]);
                    chk("overflow", overflow, e[W]);
                    fire_ovf = e[W];
                end
                stall_prev = 1'b0;
            end else if (out_valid) begin
                if (stall_prev) begin
                    chk("hold_result", result, held_res);
                    chk("hold_overflow", overflow, held_ovf);
                end
                held_res   = result;
                held_ovf   = overflow;
                stall_prev = 1'b1;
            end else begin
                stall_prev = 1'b0;
            end
            if (fire_ovf) begin
                m_sticky = 1'b1;
                if (ovf_clr) m_count = 16'h0001;
                else if (m_count != 16'hFFFF) m_count = m_count + 16'h0001;
            end else if (ovf_clr) begin
                m_sticky = 1'b0;
                m_count  = 16'h0000;
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, sat_en));
        end
    end

    // Present one beat and hold it until it is accepted. Called just after a rising edge.
    task automatic push(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s);
        int n;
        logic took;
        a = av; b = bv; sat_en = s; in_valid = 1'b1;
        n = 0; took = 1'b0;
        while (!took && n < 50) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        chk("push_accept", took, 1'b1);
    endtask

    // Send one beat into an empty pipeline, then check latency and literal outputs.
    task automatic send_check(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s,
                              input logic [W-1:0] er, input logic eo);
        int n;
        push(av, bv, s);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        chk("latency", n, 2);
        chk("lit_result", result, er);
        chk("lit_overflow", overflow, eo);
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] va [8] = '{16'h8000, 16'h7FFF, 16'h0005, 16'hFFFE,
                             16'h4000, 16'hC000, 16'h1234, 16'h8001};
    logic [W-1:0] vb [8] = '{16'h8000, 16'h8000, 16'h0007, 16'h7FFF,
                             16'hC000, 16'h4001, 16'hEDCC, 16'h0002};

    initial begin
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result, 16'h0000);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_sticky", ovf_sticky, 1'b0);
        chk("rst_count", ovf_count, 16'h0000);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);

        // Basic arithmetic, overflow and saturation with out_ready held high.
        send_check(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0);
        send_check(16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0);
        send_check(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1);
        send_check(16'h7FFF, 16'hFFFF, 1'b1, 16'h7FFF, 1'b1);
        send_check(16'h0000, 16'h8000, 1'b0, 16'h8000, 1'b1);
        send_check(16'h0000, 16'h8000, 1'b1, 16'h7FFF, 1'b1);
        send_check(16'hFFFF, 16'h8000, 1'b0, 16'h7FFF, 1'b0);
        send_check(16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1);

        // Backpressure: 4 back-to-back beats while out_ready is low for 6 cycles.
        out_ready = 1'b0;
        fork
            begin
                push(16'h0001, 16'h0000, 1'b0);
                push(16'h0002, 16'h0000, 1'b0);
                push(16'h0003, 16'h0000, 1'b0);
                push(16'h0004, 16'h0000, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                chk("bp_out_valid", out_valid, 1'b1);
                chk("bp_result", result, 16'h0001);
                chk("bp_in_ready", in_ready, 1'b0);
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (8) @(posedge clk);
        #1;
        chk("bp_drained", exp_q.size(), 0);

        // Streaming with out_ready toggling.
        fork
            begin
                for (int i = 0; i < 8; i++) push(va[i], vb[i], i[0]);
            end
            begin
                repeat (12) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        repeat (8) @(posedge clk);
        #1;
        chk("stream_drained", exp_q.size(), 0);

        // Statistics: clear, count 3 events, clear coinciding with an event, plain clear.
        ovf_clr = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        @(negedge clk);
        chk("clr0_count", ovf_count, 16'h0000);
        chk("clr0_sticky", ovf_sticky, 1'b0);
        @(posedge clk);
        #1;
        repeat (3) send_check(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1);
        @(negedge clk);
        chk("stats3_count", ovf_count, 16'h0003);
        chk("stats3_sticky", ovf_sticky, 1'b1);
        @(posedge clk);
        #1;
        push(16'h7FFF, 16'hFFFF, 1'b0);
        @(posedge clk);
        #1 ovf_clr = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        @(negedge clk);
        chk("clr_event_count", ovf_count, 16'h0001);
        chk("clr_event_sticky", ovf_sticky, 1'b1);
        @(posedge clk);
        #1 ovf_clr = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        @(negedge clk);
        chk("clr_count", ovf_count, 16'h0000);
        chk("clr_sticky", ovf_sticky, 1'b0);
        @(posedge clk);
        #1;

        // Reset with two beats in flight after one overflow event.
        send_check(16'h0000, 16'h8000, 1'b0, 16'h8000, 1'b1);
        push(16'h0011, 16'h0001, 1'b0);
        push(16'h0022, 16'h0002, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_count", ovf_count, 16'h0000);
        chk("mid_rst_sticky", ovf_sticky, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_out_valid", out_valid, 1'b0);
        chk("post_rst_count", ovf_count, 16'h0000);
        chk("post_rst_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

endmodule
